// File: rtl/sn74175_ctrl.sv
// Sequencer/arbiter that shares one SN74175 quad D register between requesters A and B.
// Optional read-back verification (ERR output) is enabled by defining SN74175_CTRL_VERIFY_EN.
module sn74175_ctrl #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic       CLK,
  input  logic       CLR_BAR,
  input  logic       REQ_A,
  input  logic [3:0] DATA_A,
  output logic       GNT_A,
  output logic       ACK_A,
  input  logic       REQ_B,
  input  logic [3:0] DATA_B,
  output logic       GNT_B,
  output logic       ACK_B,
  input  logic       CLRREQ,
  output logic       CLR_DONE,
  output logic [3:0] REG_D,
  output logic       REG_CLK,
  output logic       REG_CLR_BAR,
  input  logic [3:0] REG_Q,
  output logic [3:0] Q_OUT,
`ifdef SN74175_CTRL_VERIFY_EN
  output logic       ERR,
`endif
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_ACK, S_CLEAR
  } state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_b_q, owner_b_d;   // requester currently served (1 = B)
  logic       last_b_q, last_b_d;     // requester served most recently (1 = B)
  logic       clr_pend_q, clr_pend_d;
  logic       gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic       ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic       clr_done_q, clr_done_d;
  logic [3:0] reg_d_q, reg_d_d;
  logic       reg_clk_q, reg_clk_d;
  logic       reg_clr_bar_q, reg_clr_bar_d;
  logic [3:0] q_out_q, q_out_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic pick_b, any_req, clr_go, cnt_zero;

  assign any_req  = REQ_A | REQ_B;
  // On a tie the requester not served last wins.
  assign pick_b   = REQ_B & (~REQ_A | ~last_b_q);
  assign clr_go   = CLRREQ | clr_pend_q;
  assign cnt_zero = (cnt_q == 4'd0);

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_b_d  = owner_b_q;
    last_b_d   = last_b_q;
    clr_pend_d = clr_pend_q;
    if (CLRREQ && state_q inside {S_SETUP, S_PULSE, S_HOLD, S_ACK}) clr_pend_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (clr_go) begin
          state_d    = S_CLEAR;
          cnt_d      = STROBE_LOAD;
          clr_pend_d = 1'b0;
        end else if (any_req) begin
          state_d   = S_SETUP;
          cnt_d     = SETUP_LOAD;
          owner_b_d = pick_b;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_PULSE;
          cnt_d   = STROBE_LOAD;
        end else cnt_d = cnt_q - 4'd1;
      end
      S_PULSE: begin
        if (cnt_zero) state_d = S_HOLD;
        else          cnt_d   = cnt_q - 4'd1;
      end
      S_HOLD:  state_d = S_ACK;
      S_ACK: begin
        state_d  = S_IDLE;
        last_b_d = owner_b_q;
      end
      S_CLEAR: begin
        if (cnt_zero) state_d = S_IDLE;
        else          cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered-output logic.
  always_comb begin
    gnt_a_d       = gnt_a_q;
    gnt_b_d       = gnt_b_q;
    ack_a_d       = 1'b0;
    ack_b_d       = 1'b0;
    clr_done_d    = 1'b0;
    reg_d_d       = reg_d_q;
    reg_clk_d     = reg_clk_q;
    reg_clr_bar_d = 1'b1;
    q_out_d       = q_out_q;
    busy_d        = (state_d != S_IDLE);
    err_d         = err_q;
    unique case (state_q)
      S_IDLE: begin
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        if (clr_go) begin
          reg_clr_bar_d = 1'b0;
        end else if (any_req) begin
          gnt_a_d = ~pick_b;
          gnt_b_d = pick_b;
          reg_d_d = pick_b ? DATA_B : DATA_A;
        end
      end
      S_SETUP: if (cnt_zero) reg_clk_d = 1'b1;
      S_PULSE: if (cnt_zero) reg_clk_d = 1'b0;
      S_HOLD: begin
        q_out_d = REG_Q;
        if (REG_Q != reg_d_q) err_d = 1'b1;
      end
      S_ACK: begin
        ack_a_d = ~owner_b_q;
        ack_b_d = owner_b_q;
      end
      S_CLEAR: begin
        if (!cnt_zero) begin
          reg_clr_bar_d = 1'b0;
        end else begin
          q_out_d    = 4'd0;
          clr_done_d = 1'b1;
          if (REG_Q != 4'd0) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge CLR_BAR) begin
    if (!CLR_BAR) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      owner_b_q     <= 1'b0;
      last_b_q      <= 1'b1;
      clr_pend_q    <= 1'b0;
      gnt_a_q       <= 1'b0;
      gnt_b_q       <= 1'b0;
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      clr_done_q    <= 1'b0;
      reg_d_q       <= 4'd0;
      reg_clk_q     <= 1'b0;
      reg_clr_bar_q <= 1'b0;
      q_out_q       <= 4'd0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_b_q     <= owner_b_d;
      last_b_q      <= last_b_d;
      clr_pend_q    <= clr_pend_d;
      gnt_a_q       <= gnt_a_d;
      gnt_b_q       <= gnt_b_d;
      ack_a_q       <= ack_a_d;
      ack_b_q       <= ack_b_d;
      clr_done_q    <= clr_done_d;
      reg_d_q       <= reg_d_d;
      reg_clk_q     <= reg_clk_d;
      reg_clr_bar_q <= reg_clr_bar_d;
      q_out_q       <= q_out_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign GNT_A       = gnt_a_q;
  assign GNT_B       = gnt_b_q;
  assign ACK_A       = ack_a_q;
  assign ACK_B       = ack_b_q;
  assign CLR_DONE    = clr_done_q;
  assign REG_D       = reg_d_q;
  assign REG_CLK     = reg_clk_q;
  assign REG_CLR_BAR = reg_clr_bar_q;
  assign Q_OUT       = q_out_q;
  assign BUSY        = busy_q;
`ifdef SN74175_CTRL_VERIFY_EN
  assign ERR         = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_sn74175_ctrl.sv
// Bench for sn74175_ctrl: two controllers (default and SETUP=3/STROBE=2 timing), each driving
// a behavioural 74175; write results are checked against a scoreboard of expected readbacks.
module tb_sn74175_ctrl;

  logic clk = 1'b0;
  logic clr_bar = 1'b0;
  always #5 clk = ~clk;

  logic       req_a = 0, req_b = 0, clrreq = 0;
  logic [3:0] data_a = 0, data_b = 0;
  logic       gnt_a, gnt_b, ack_a, ack_b, clr_done, reg_clk, reg_clr_bar, busy;
  logic [3:0] reg_d, reg_q, q_out;
  logic       req_a2 = 0, req_b2 = 0, clrreq2 = 0;
  logic [3:0] data_a2 = 0, data_b2 = 0;
  logic       gnt_a2, gnt_b2, ack_a2, ack_b2, clr_done2, reg_clk2, reg_clr_bar2, busy2;
  logic [3:0] reg_d2, reg_q2, q_out2;
`ifdef SN74175_CTRL_VERIFY_EN
  logic       err, err2;
`endif

  sn74175_ctrl #(.SETUP_CYC(1), .STROBE_CYC(1)) dut (
    .CLK(clk), .CLR_BAR(clr_bar),
    .REQ_A(req_a), .DATA_A(data_a), .GNT_A(gnt_a), .ACK_A(ack_a),
    .REQ_B(req_b), .DATA_B(data_b), .GNT_B(gnt_b), .ACK_B(ack_b),
    .CLRREQ(clrreq), .CLR_DONE(clr_done),
    .REG_D(reg_d), .REG_CLK(reg_clk), .REG_CLR_BAR(reg_clr_bar), .REG_Q(reg_q),
    .Q_OUT(q_out),
`ifdef SN74175_CTRL_VERIFY_EN
    .ERR(err),
`endif
    .BUSY(busy)
  );

  sn74175_ctrl #(.SETUP_CYC(3), .STROBE_CYC(2)) dut2 (
    .CLK(clk), .CLR_BAR(clr_bar),
    .REQ_A(req_a2), .DATA_A(data_a2), .GNT_A(gnt_a2), .ACK_A(ack_a2),
    .REQ_B(req_b2), .DATA_B(data_b2), .GNT_B(gnt_b2), .ACK_B(ack_b2),
    .CLRREQ(clrreq2), .CLR_DONE(clr_done2),
    .REG_D(reg_d2), .REG_CLK(reg_clk2), .REG_CLR_BAR(reg_clr_bar2), .REG_Q(reg_q2),
    .Q_OUT(q_out2),
`ifdef SN74175_CTRL_VERIFY_EN
    .ERR(err2),
`endif
    .BUSY(busy2)
  );

  // Behavioural 74175 parts; stuck2 forces Q2 of the first part to 0.
  logic [3:0] mq, mq2;
  logic       stuck2 = 1'b0;
  always @(posedge reg_clk or negedge reg_clr_bar)
    if (!reg_clr_bar) mq <= 4'd0; else mq <= reg_d;
  always @(posedge reg_clk2 or negedge reg_clr_bar2)
    if (!reg_clr_bar2) mq2 <= 4'd0; else mq2 <= reg_d2;
  assign reg_q  = mq & ~{1'b0, stuck2, 2'b00};
  assign reg_q2 = mq2;

  logic overlap = 1'b0;
  always @(negedge clk)
    if ((gnt_a & gnt_b) | (gnt_a2 & gnt_b2)) overlap = 1'b1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       is_b;
    logic [3:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic any_ack(input int which);
    return (which == 1) ? (ack_a | ack_b) : (ack_a2 | ack_b2);
  endfunction

  task automatic wait_ack(input int which, output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (!any_ack(which) && cyc < 40);
    if (cyc >= 40) check("ack_timeout", 8'(any_ack(which)), 8'd1);
  endtask

  task automatic score(input int which);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 8'(sb.size()), 8'd1);
    end else begin
      e = sb.pop_front();
      if (which == 1) begin
        check("ack_who", {ack_a, ack_b}, {~e.is_b, e.is_b});
        check("q_out", 8'(q_out), 8'(e.val));
      end else begin
        check("ack_who2", {ack_a2, ack_b2}, {~e.is_b, e.is_b});
        check("q_out2", 8'(q_out2), 8'(e.val));
      end
    end
  endtask

  initial begin
    int cyc, lat;
    logic acks;

    // Reset state.
    step(2);
    check("rst_flags", {gnt_a, gnt_b, ack_a, ack_b, clr_done, reg_clk, reg_clr_bar, busy}, 8'h00);
    check("rst_reg_d", 8'(reg_d), 8'h00);
    check("rst_q_out", 8'(q_out), 8'h00);
    clr_bar = 1'b1;
    step(1);
    check("clr_bar_rise", 8'(reg_clr_bar), 8'd1);

    // Single write from A.
    req_a = 1; data_a = 4'hA;
    sb.push_back('{1'b0, 4'hA});
    step(1);
    check("gnt_a_rise", {gnt_a, gnt_b, busy, reg_clk}, 8'b1010);
    req_a = 0;
    step(1);
    check("reg_clk_rise", 8'(reg_clk), 8'd1);
    wait_ack(1, cyc);
    lat = cyc + 1;
    check("lat_a", 8'(lat), 8'd4);
    score(1);
    check("reg_q_a", 8'(reg_q), 8'h0A);

    // Round-robin from a fresh reset.
    clr_bar = 0; step(1); clr_bar = 1; step(1);
    req_a = 1; req_b = 1; data_a = 4'h3; data_b = 4'h5;
    for (int k = 0; k < 4; k++) sb.push_back('{k[0], (k[0] ? 4'h5 : 4'h3)});
    for (int k = 0; k < 4; k++) begin
      wait_ack(1, cyc);
      if (k == 3) begin req_a = 0; req_b = 0; end
      score(1);
    end

    // Clear has priority over a simultaneous request.
    clrreq = 1; req_b = 1; data_b = 4'h7;
    step(1);
    check("clear_low", {reg_clr_bar, gnt_a, gnt_b, busy}, 8'b0001);
    clrreq = 0;
    step(1);
    check("clear_done", {clr_done, reg_clr_bar, gnt_b}, 8'b110);
    check("clear_q_out", 8'(q_out), 8'h00);
    check("clear_reg_q", 8'(reg_q), 8'h00);
    sb.push_back('{1'b1, 4'h7});
    step(1);
    check("gnt_b_after_clr", {gnt_a, gnt_b}, 8'b01);
    req_b = 0;
    wait_ack(1, cyc);
    score(1);

    // Long setup/strobe timing with data changed after grant.
    req_b2 = 1; data_b2 = 4'h6;
    sb.push_back('{1'b1, 4'h6});
    step(1);
    check("gnt_b2", {gnt_a2, gnt_b2}, 8'b01);
    data_b2 = 4'h9; req_b2 = 0;
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      check("setup_hold", {reg_clk2, reg_d2}, {1'b0, 4'h6});
      step(1); lat++;
    end
    for (int i = 0; i < 2; i++) begin
      check("strobe_high", {reg_clk2, reg_d2}, {1'b1, 4'h6});
      step(1); lat++;
    end
    check("strobe_end", 8'(reg_clk2), 8'd0);
    wait_ack(2, cyc);
    check("lat_b2", 8'(lat + cyc), 8'd7);
    score(2);

    // Reset in the middle of the clock strobe aborts the write.
    req_a = 1; data_a = 4'hC;
    step(1);
    check("gnt_a_abort", 8'(gnt_a), 8'd1);
    req_a = 0;
    step(1);
    check("pulse_high", 8'(reg_clk), 8'd1);
    #2 clr_bar = 0;
    #1 check("abort_async", {reg_clk, reg_clr_bar, gnt_a, busy, reg_q}, 8'h00);
    step(1);
    clr_bar = 1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      acks = acks | ack_a | ack_b;
    end
    check("no_ack_abort", 8'(acks), 8'd0);
    req_a = 1; data_a = 4'h2;
    sb.push_back('{1'b0, 4'h2});
    step(1);
    check("gnt_a_post", 8'(gnt_a), 8'd1);
    req_a = 0;
    wait_ack(1, cyc);
    score(1);

`ifdef SN74175_CTRL_VERIFY_EN
    check("err_clean", 8'(err), 8'd0);
    stuck2 = 1;
    req_a = 1; data_a = 4'hF;
    sb.push_back('{1'b0, 4'hB});
    step(1); req_a = 0;
    wait_ack(1, cyc);
    score(1);
    check("err_set", 8'(err), 8'd1);
    stuck2 = 0;
    req_a = 1; data_a = 4'h5;
    sb.push_back('{1'b0, 4'h5});
    step(1); req_a = 0;
    wait_ack(1, cyc);
    score(1);
    check("err_sticky", 8'(err), 8'd1);
    clr_bar = 0; step(1);
    check("err_reset", 8'(err), 8'd0);
    clr_bar = 1; step(1);
`endif

    check("gnt_overlap", 8'(overlap), 8'd0);
    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
